// File: rtl/pulse_generator_pkg.sv
// Shared encodings and constants for the pulse generator channels.
package pulse_generator_pkg;

  // Channel FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Smallest phase length; a programmed length of zero is clamped up to this.
  localparam int unsigned MIN_LEN = 1;

endpackage

// File: rtl/pulse_generator_channel.sv
// Single pulse-train channel: FSM, phase counter, pulse counter and latched config.
module pulse_generator_channel
  import pulse_generator_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned NUM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 idle_level,
  input  logic [CNT_WIDTH-1:0] high_len,
  input  logic [CNT_WIDTH-1:0] low_len,
  input  logic [NUM_WIDTH-1:0] pulse_count,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [NUM_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] high_q;
  logic [CNT_WIDTH-1:0] low_q;
  logic                 idle_q;
  logic [CNT_WIDTH-1:0] high_reload;
  logic [CNT_WIDTH-1:0] low_reload;

  // Counter reload values: max(len, 1) - 1, so a phase lasts max(len, 1) cycles.
  assign high_reload = (high_len == '0) ? '0 : high_len - CNT_WIDTH'(MIN_LEN);
  assign low_reload  = (low_len  == '0) ? '0 : low_len  - CNT_WIDTH'(MIN_LEN);

  // Channel FSM with registered pin level, busy and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      remaining <= '0;
      high_q    <= '0;
      low_q     <= '0;
      idle_q    <= 1'b0;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          out <= idle_level;
          if (start && !stop) begin
            high_q    <= high_reload;
            low_q     <= low_reload;
            idle_q    <= idle_level;
            remaining <= pulse_count;
            cnt       <= high_reload;
            out       <= ~idle_level;
            busy      <= 1'b1;
            state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (stop) begin
            out   <= idle_level;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            if (remaining == NUM_WIDTH'(1)) begin
              out   <= idle_level;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              // remaining == 0 marks continuous mode and is never decremented
              if (remaining != '0) remaining <= remaining - NUM_WIDTH'(1);
              cnt   <= low_q;
              out   <= idle_q;
              state <= ST_GAP;
            end
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        ST_GAP: begin
          if (stop) begin
            out   <= idle_level;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            cnt   <= high_q;
            out   <= ~idle_q;
            state <= ST_ACTIVE;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          out   <= idle_level;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_generator.sv
// WIDTH independent pulse-train channels sharing one timing configuration.
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned NUM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     start,
  input  logic [WIDTH-1:0]     stop,
  input  logic [WIDTH-1:0]     idle_level,
  input  logic [CNT_WIDTH-1:0] high_len,
  input  logic [CNT_WIDTH-1:0] low_len,
  input  logic [NUM_WIDTH-1:0] pulse_count,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     busy,
  output logic [WIDTH-1:0]     done
);

  // One channel per output pin; shared config fans out to all of them.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    pulse_generator_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .NUM_WIDTH (NUM_WIDTH)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .start       (start[i]),
      .stop        (stop[i]),
      .idle_level  (idle_level[i]),
      .high_len    (high_len),
      .low_len     (low_len),
      .pulse_count (pulse_count),
      .out         (out[i]),
      .busy        (busy[i]),
      .done        (done[i])
    );
  end

endmodule
